int_to_fp_pipe: RTL and testbench

- Native, fully parametrised pipelined integer-to-floating-point converter; replaces the vendor-IP converter wrapper.
- Supports any integer width, signed or unsigned input, and any IEEE-754-style binary format (EXP_WIDTH/MAN_WIDTH).
- Rounds to nearest-even and reports inexact and overflow flags.
- Sits between integer accumulators (pixel counts, correlation sums) and the FP datapath of the LCMV classifier, with full valid/ready backpressure.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/int_to_fp_lzc.sv | 28 ++
 rtl/int_to_fp_pipe.sv | 145 ++++++++++++++
 tb/tb_int_to_fp_pipe.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Floating-point format helpers shared by the integer-to-float datapath.
// Packages cannot be parametrised, so users size formats through these functions.
package fp_pkg;

    function automatic int fp_width(input int e, input int m);
        return 1 + e + m;
    endfunction

    function automatic int fp_bias(input int e);
        return (1 << (e - 1)) - 1;
    endfunction

    function automatic int fp_exp_ones(input int e);
        return (1 << e) - 1;
    endfunction

    localparam int SP_EXP_W = 8;
    localparam int SP_MAN_W = 23;
    localparam int HP_EXP_W = 5;
    localparam int HP_MAN_W = 10;

    typedef struct packed {
        logic                sign;
        logic [SP_EXP_W-1:0] exp;
        logic [SP_MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic                sign;
        logic [HP_EXP_W-1:0] exp;
        logic [HP_MAN_W-1:0] man;
    } fp16_t;

endpackage

// File: rtl/int_to_fp_lzc.sv
// Combinational leading-zero counter; count equals WIDTH when the input is zero.
module int_to_fp_lzc
    import fp_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic found;

    always_comb begin
        count = CNT_W'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && din[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end

    assign zero = ~|din;

endmodule

// File: rtl/int_to_fp_pipe.sv
// Three-stage integer-to-float converter with round-to-nearest-even,
// inexact/overflow flags and full valid/ready backpressure.
module int_to_fp_pipe
    import fp_pkg::*;
#(
    parameter  int INT_WIDTH  = 32,
    parameter  int INT_SIGNED = 0,
    parameter  int EXP_WIDTH  = 8,
    parameter  int MAN_WIDTH  = 23,
    localparam int FP_WIDTH   = fp_width(EXP_WIDTH, MAN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FP_WIDTH-1:0]  out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_inexact,
    output logic                 out_overflow
);

    localparam int LZ_W     = $clog2(INT_WIDTH + 1);
    localparam int XW       = EXP_WIDTH + LZ_W + 2;
    localparam int BIAS     = fp_bias(EXP_WIDTH);
    localparam int EXP_ONES = fp_exp_ones(EXP_WIDTH);
    localparam int NW       = INT_WIDTH - 1;
    localparam int EXT_W    = NW + MAN_WIDTH + 1;
    localparam int RES_W    = FP_WIDTH + 2;

    if (INT_WIDTH < 2 || EXP_WIDTH < 2 || MAN_WIDTH < 1) begin : g_param_check
        $fatal(1, "int_to_fp_pipe: INT_WIDTH>=2, EXP_WIDTH>=2, MAN_WIDTH>=1 required");
    end

    // Rounds the normalised magnitude (implicit leading one dropped) and
    // packs {result, inexact, overflow}; overflow saturates to infinity.
    function automatic logic [RES_W-1:0] round_pack(
        input logic            sign,
        input logic            zero,
        input logic [LZ_W-1:0] lz,
        input logic [NW-1:0]   norm
    );
        logic [EXT_W-1:0]     ext;
        logic [MAN_WIDTH-1:0] frac;
        logic                 guard;
        logic                 sticky;
        logic                 up;
        logic [MAN_WIDTH:0]   man_r;
        logic [XW-1:0]        exp_r;
        logic                 ovf;
        logic                 inx;
        logic [FP_WIDTH-1:0]  res;
        ext    = {norm, {(MAN_WIDTH + 1){1'b0}}};
        frac   = ext[EXT_W-1 -: MAN_WIDTH];
        guard  = ext[EXT_W-1-MAN_WIDTH];
        sticky = |ext[EXT_W-2-MAN_WIDTH:0];
        up     = guard & (sticky | frac[0]);
        man_r  = {1'b0, frac} + {{MAN_WIDTH{1'b0}}, up};
        exp_r  = XW'(INT_WIDTH - 1 + BIAS) - XW'(lz) + XW'(man_r[MAN_WIDTH]);
        ovf    = (exp_r >= XW'(EXP_ONES));
        inx    = guard | sticky | ovf;
        if (zero) begin
            res = '0;
            inx = 1'b0;
            ovf = 1'b0;
        end else if (ovf) begin
            res = {sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
        end else begin
            res = {sign, exp_r[EXP_WIDTH-1:0], man_r[MAN_WIDTH-1:0]};
        end
        return {res, inx, ovf};
    endfunction

    logic                 vld_p0, vld_p1, vld_p2;
    logic                 adv_p0, adv_p1, adv_p2;
    logic                 in_sign;
    logic [INT_WIDTH-1:0] in_mag;
    logic                 sign_p0;
    logic [INT_WIDTH-1:0] mag_p0;
    logic [LZ_W-1:0]      lz_cnt;
    logic                 lz_zero;
    logic                 sign_p1;
    logic                 zero_p1;
    logic [LZ_W-1:0]      lz_p1;
    logic [NW-1:0]        norm_p1;
    logic [FP_WIDTH-1:0]  data_p2;
    logic                 inexact_p2;
    logic                 overflow_p2;

    // A stage may load when it is empty or its content moves on this cycle.
    assign adv_p2   = out_ready | ~vld_p2;
    assign adv_p1   = adv_p2 | ~vld_p1;
    assign adv_p0   = adv_p1 | ~vld_p0;
    assign in_ready = adv_p0;

    assign in_sign = (INT_SIGNED != 0) && in_data[INT_WIDTH-1];
    assign in_mag  = in_sign ? -in_data : in_data;

    int_to_fp_lzc #(.WIDTH(INT_WIDTH)) u_lzc (
        .din   (mag_p0),
        .count (lz_cnt),
        .zero  (lz_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            data_p2     <= '0;
            inexact_p2  <= 1'b0;
            overflow_p2 <= 1'b0;
        end else begin
            if (adv_p0) vld_p0 <= in_valid;
            if (adv_p1) vld_p1 <= vld_p0;
            if (adv_p2) vld_p2 <= vld_p1;
            // stage 3: round, pack and flag
            if (adv_p2 && vld_p1) begin
                {data_p2, inexact_p2, overflow_p2} <= round_pack(sign_p1, zero_p1, lz_p1, norm_p1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // stage 1: sign and magnitude
        if (adv_p0 && in_valid) begin
            sign_p0 <= in_sign;
            mag_p0  <= in_mag;
        end
        // stage 2: normalise
        if (adv_p1 && vld_p0) begin
            sign_p1 <= sign_p0;
            zero_p1 <= lz_zero;
            lz_p1   <= lz_cnt;
            norm_p1 <= NW'(mag_p0 << lz_cnt);
        end
    end

    assign out_valid    = vld_p2;
    assign out_data     = data_p2;
    assign out_inexact  = inexact_p2;
    assign out_overflow = overflow_p2;

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Bench for int_to_fp_pipe: unsigned single, signed single and half-precision-style
// instances checked against directed values and an arithmetic reference model.
module tb_int_to_fp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [31:0] id0, id1, id2;
    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic        inx0, inx1, inx2, ovf0, ovf1, ovf2;
    logic [31:0] od0, od1;
    logic [15:0] od2;

    int vectors     = 0;
    int miscompares = 0;

    int_to_fp_pipe #(.INT_WIDTH(32), .INT_SIGNED(0), .EXP_WIDTH(8), .MAN_WIDTH(23)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_data(id0), .in_valid(iv[0]), .in_ready(ir0),
        .out_data(od0), .out_valid(ov0), .out_ready(ordy[0]),
        .out_inexact(inx0), .out_overflow(ovf0));

    int_to_fp_pipe #(.INT_WIDTH(32), .INT_SIGNED(1), .EXP_WIDTH(8), .MAN_WIDTH(23)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_data(id1), .in_valid(iv[1]), .in_ready(ir1),
        .out_data(od1), .out_valid(ov1), .out_ready(ordy[1]),
        .out_inexact(inx1), .out_overflow(ovf1));

    int_to_fp_pipe #(.INT_WIDTH(32), .INT_SIGNED(0), .EXP_WIDTH(5), .MAN_WIDTH(10)) u_half (
        .clk(clk), .rst_n(rst_n), .in_data(id2), .in_valid(iv[2]), .in_ready(ir2),
        .out_data(od2), .out_valid(ov2), .out_ready(ordy[2]),
        .out_inexact(inx2), .out_overflow(ovf2));

    // Reference: value -> exponent by magnitude, mantissa by quotient/remainder,
    // ties to even on the quotient.  Returns {overflow, inexact, data}.
    function automatic logic [33:0] ref_fp(input int d, input logic [31:0] x);
        int                E, M, e, bexp, top;
        bit                neg, inx, ovf;
        longint unsigned   mag, q, r, half, res;
        E   = (d == 2) ? 5 : 8;
        M   = (d == 2) ? 10 : 23;
        neg = (d == 1) && x[31];
        mag = neg ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
        if (mag == 0) return '0;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        inx = 1'b0;
        ovf = 1'b0;
        if (e <= M) begin
            q = mag << (M - e);
        end else begin
            q    = mag >> (e - M);
            r    = mag - (q << (e - M));
            half = 64'd1 << (e - M - 1);
            inx  = (r != 0);
            if (r > half || (r == half && q[0])) q++;
            if (q == (64'd1 << (M + 1))) begin
                q = q >> 1;
                e++;
            end
        end
        bexp = e + (1 << (E - 1)) - 1;
        top  = (1 << E) - 1;
        if (bexp >= top) begin
            ovf = 1'b1;
            inx = 1'b1;
            res = (64'(neg) << (E + M)) | (64'(top) << M);
        end else begin
            res = (64'(neg) << (E + M)) | (64'(bexp) << M) | (q - (64'd1 << M));
        end
        return {ovf, inx, res[31:0]};
    endfunction

    // Drives one DUT for one cycle (others idle) and samples it 1 time unit after the falling edge.
    task automatic clk_step(input int d, input logic v, input logic [31:0] x, input logic rdy,
                            output logic ir, output logic ovv, output logic [31:0] od,
                            output logic inx, output logic ovf);
        @(negedge clk);
        iv      = 3'b000;
        ordy    = 3'b111;
        iv[d]   = v;
        ordy[d] = rdy;
        case (d)
            0:       id0 = x;
            1:       id1 = x;
            default: id2 = x;
        endcase
        #1;
        case (d)
            0:       begin ir = ir0; ovv = ov0; od = od0;           inx = inx0; ovf = ovf0; end
            1:       begin ir = ir1; ovv = ov1; od = od1;           inx = inx1; ovf = ovf1; end
            default: begin ir = ir2; ovv = ov2; od = {16'h0, od2}; inx = inx2; ovf = ovf2; end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv    = 3'b000;
        ordy  = 3'b111;
        id0   = '0;
        id1   = '0;
        id2   = '0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({ov0, inx0, ovf0, od0} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_uns: got %h required 0", {ov0, inx0, ovf0, od0});
        end
        vectors++;
        if ({ov1, inx1, ovf1, od1} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_sgn: got %h required 0", {ov1, inx1, ovf1, od1});
        end
        vectors++;
        if ({ov2, inx2, ovf2, od2} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_half: got %h required 0", {ov2, inx2, ovf2, od2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({ir0, ir1, ir2} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b required 111", {ir0, ir1, ir2});
        end
    endtask

    task automatic test_unsigned_stream();
        logic [31:0] ins  [4];
        logic [31:0] expd [4];
        logic        ir, ovv, inx, ovf, exp_v;
        logic [31:0] od;
        ins  = '{32'h0, 32'h1, 32'h00FF_FFFF, 32'hFFFF_FFFF};
        expd = '{32'h0, 32'h3F80_0000, 32'h4B7F_FFFF, 32'h4F80_0000};
        for (int c = 0; c < 8; c++) begin
            clk_step(0, c < 4, ins[c % 4], 1'b1, ir, ovv, od, inx, ovf);
            if (c < 4) begin
                vectors++;
                if (ir !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_in_ready c=%0d: got %b required 1", c, ir);
                end
            end
            exp_v = (c >= 3 && c <= 6);
            vectors++;
            if (ovv !== exp_v) begin
                miscompares++;
                $display("FAIL stream_valid c=%0d: got %b required %b", c, ovv, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if ({ovf, inx, od} !== {1'b0, c == 6, expd[c - 3]}) begin
                    miscompares++;
                    $display("FAIL stream_data c=%0d: got %h required %h", c, {ovf, inx, od},
                             {1'b0, c == 6, expd[c - 3]});
                end
            end
        end
    endtask

    task automatic test_rne();
        logic [31:0] ins  [2];
        logic [33:0] expv [2];
        logic        ir, ovv, inx, ovf;
        logic [31:0] od;
        int          sent, got;
        ins  = '{32'h0100_0001, 32'h0100_0003};
        expv = '{{2'b01, 32'h4B80_0000}, {2'b01, 32'h4B80_0002}};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            clk_step(0, sent < 2, ins[sent % 2], 1'b1, ir, ovv, od, inx, ovf);
            if (sent < 2 && ir) sent++;
            if (ovv) begin
                vectors++;
                if ({ovf, inx, od} !== expv[got]) begin
                    miscompares++;
                    $display("FAIL rne[%0d]: got %h required %h", got, {ovf, inx, od}, expv[got]);
                end
                got++;
            end
        end
        vectors++;
        if (got != 2) begin
            miscompares++;
            $display("FAIL rne_count: got %0d required 2", got);
        end
    endtask

    task automatic test_signed();
        logic [31:0] ins  [3];
        logic [33:0] expv [3];
        logic        ir, ovv, inx, ovf;
        logic [31:0] od;
        int          sent, got;
        ins  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        expv = '{{2'b00, 32'hBF80_0000}, {2'b00, 32'hCF00_0000}, {2'b01, 32'h4F00_0000}};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            clk_step(1, sent < 3, ins[sent % 3], 1'b1, ir, ovv, od, inx, ovf);
            if (sent < 3 && ir) sent++;
            if (ovv) begin
                vectors++;
                if ({ovf, inx, od} !== expv[got]) begin
                    miscompares++;
                    $display("FAIL signed[%0d]: got %h required %h", got, {ovf, inx, od}, expv[got]);
                end
                got++;
            end
        end
        vectors++;
        if (got != 3) begin
            miscompares++;
            $display("FAIL signed_count: got %0d required 3", got);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ins  [3];
        logic [33:0] expv [3];
        logic        ir, ovv, inx, ovf;
        logic [31:0] od;
        int          sent, got;
        ins  = '{32'h0001_0000, 32'd65504, 32'd65520};
        expv = '{{2'b11, 32'h7C00}, {2'b00, 32'h7BFF}, {2'b11, 32'h7C00}};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            clk_step(2, sent < 3, ins[sent % 3], 1'b1, ir, ovv, od, inx, ovf);
            if (sent < 3 && ir) sent++;
            if (ovv) begin
                vectors++;
                if ({ovf, inx, od} !== expv[got]) begin
                    miscompares++;
                    $display("FAIL overflow[%0d]: got %h required %h", got, {ovf, inx, od}, expv[got]);
                end
                got++;
            end
        end
        vectors++;
        if (got != 3) begin
            miscompares++;
            $display("FAIL overflow_count: got %0d required 3", got);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ops [6];
        logic [33:0] expq[$];
        logic [33:0] held, e;
        logic        ir, ovv, inx, ovf, rdy, have_held;
        logic [31:0] od;
        int          sent, got;
        for (int i = 0; i < 6; i++) begin
            ops[i] = $urandom >> $urandom_range(0, 24);
            expq.push_back(ref_fp(0, ops[i]));
        end
        sent      = 0;
        got       = 0;
        have_held = 1'b0;
        held      = '0;
        for (int c = 0; c < 6; c++) begin
            clk_step(0, sent < 6, ops[sent % 6], 1'b0, ir, ovv, od, inx, ovf);
            if (sent < 6 && ir) sent++;
            if (ovv) begin
                if (have_held) begin
                    vectors++;
                    if ({ovf, inx, od} !== held) begin
                        miscompares++;
                        $display("FAIL bp_hold c=%0d: got %h required %h", c, {ovf, inx, od}, held);
                    end
                end
                held      = {ovf, inx, od};
                have_held = 1'b1;
            end
        end
        vectors++;
        if (sent != 3 || ir !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d accepts in_ready=%b required 3 accepts in_ready=0", sent, ir);
        end
        for (int c = 0; c < 60 && got < 6; c++) begin
            rdy = (c % 2 == 0);
            clk_step(0, sent < 6, ops[sent % 6], rdy, ir, ovv, od, inx, ovf);
            if (sent < 6 && ir) sent++;
            if (ovv && rdy) begin
                e = expq.pop_front();
                vectors++;
                if ({ovf, inx, od} !== e) begin
                    miscompares++;
                    $display("FAIL bp_data[%0d]: got %h required %h", got, {ovf, inx, od}, e);
                end
                got++;
            end
        end
        vectors++;
        if (got != 6) begin
            miscompares++;
            $display("FAIL bp_count: got %0d required 6", got);
        end
        for (int c = 0; c < 5; c++) begin
            clk_step(0, 1'b0, 32'h0, 1'b1, ir, ovv, od, inx, ovf);
            vectors++;
            if (ovv !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_duplicate c=%0d: got out_valid=%b data=%h required 0", c, ovv, od);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic        ir, ovv, inx, ovf;
        logic [31:0] od;
        clk_step(0, 1'b1, 32'd1234, 1'b1, ir, ovv, od, inx, ovf);
        clk_step(0, 1'b1, 32'd98765, 1'b1, ir, ovv, od, inx, ovf);
        @(negedge clk);
        iv    = 3'b000;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ov0 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_valid: got %b required 0", ov0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            clk_step(0, 1'b0, 32'h0, 1'b1, ir, ovv, od, inx, ovf);
            vectors++;
            if (ovv !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_stale c=%0d: got out_valid=%b data=%h required 0", c, ovv, od);
            end
        end
        for (int c = 0; c < 5; c++) begin
            clk_step(0, c == 0, 32'd5, 1'b1, ir, ovv, od, inx, ovf);
            vectors++;
            if (ovv !== (c == 3)) begin
                miscompares++;
                $display("FAIL midreset_latency c=%0d: got %b required %b", c, ovv, c == 3);
            end
            if (c == 3) begin
                vectors++;
                if ({ovf, inx, od} !== {2'b00, 32'h40A0_0000}) begin
                    miscompares++;
                    $display("FAIL midreset_data: got %h required %h", {ovf, inx, od}, {2'b00, 32'h40A0_0000});
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] specials [8];
        logic [33:0] expq[$];
        logic [33:0] e;
        logic [31:0] x, od;
        logic        v, rdy, ir, ovv, inx, ovf;
        int          sent, got;
        specials = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                     32'hFFFF_FFFF, 32'hFFFF, 32'd65520, 32'd65504};
        for (int d = 0; d < 3; d++) begin
            sent = 0;
            got  = 0;
            expq.delete();
            x    = '0;
            for (int c = 0; c < 600 && got < 40; c++) begin
                if (sent < 40) begin
                    case ($urandom_range(0, 2))
                        0:       x = $urandom;
                        1:       x = $urandom >> $urandom_range(0, 31);
                        default: x = specials[$urandom_range(0, 7)];
                    endcase
                end
                v   = (sent < 40) && ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 9) < 7);
                clk_step(d, v, x, rdy, ir, ovv, od, inx, ovf);
                if (v && ir) begin
                    expq.push_back(ref_fp(d, x));
                    sent++;
                end
                if (ovv && rdy) begin
                    vectors++;
                    if (expq.size() == 0) begin
                        miscompares++;
                        $display("FAIL random_extra d=%0d: got %h required no output", d, od);
                    end else begin
                        e = expq.pop_front();
                        if ({ovf, inx, od} !== e) begin
                            miscompares++;
                            $display("FAIL random d=%0d n=%0d: got %h required %h", d, got, {ovf, inx, od}, e);
                        end
                    end
                    got++;
                end
            end
            vectors++;
            if (got != 40) begin
                miscompares++;
                $display("FAIL random_count d=%0d: got %0d required 40", d, got);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_stream();
        test_rne();
        test_signed();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
